// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer: state encoding,
// chunk width and the chunk-index width helper.
package multiword_add_seq_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk index width: clog2(words), never below one bit.
  function automatic int idx_w(input int words);
    if (words <= 2) begin
      return 1;
    end else begin
      return $clog2(words);
    end
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Client-side bus of the multi-word adder. The ovf signal exists only when
// MWADD_OVF_EN is defined.
interface multiword_add_seq_if #(
  parameter int W     = 8,
  parameter int WORDS = 4
);
  logic               start;
  logic               sub;
  logic [W*WORDS-1:0] a;
  logic [W*WORDS-1:0] b;
  logic               busy;
  logic               done;
  logic [W*WORDS-1:0] sum;
  logic               cout;
`ifdef MWADD_OVF_EN
  logic               ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
`else
  modport master (output start, sub, a, b, input busy, done, sum, cout);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/multiword_add_seq_ripple_carry8.sv
// ripple_carry8: the shared 8-bit ripple-carry adder slice.
module ripple_carry8
  import multiword_add_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  // Bit-serial carry chain through CHUNK_W full adders.
  always_comb begin
    logic c_v;
    c_v = ci;
    s   = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c_v;
      c_v  = (a[i] & b[i]) | (c_v & (a[i] ^ b[i]));
    end
    co = c_v;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract computed one 8-bit chunk per clock through a single
// ripple_carry8 slice, LSB chunk first. Define MWADD_OVF_EN for the ovf output.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus
);

  localparam int IDXW = idx_w(WORDS);

  state_t                      state_r;
  state_t                      state_s;
  logic [WORDS-1:0][W-1:0]     a_r;
  logic [WORDS-1:0][W-1:0]     b_r;
  logic [WORDS-1:0][W-1:0]     sum_r;
  logic [IDXW-1:0]             idx_r;
  logic                        carry_r;
  logic                        cout_r;
  logic                        last_s;
  logic [CHUNK_W-1:0]          slice_s;
  logic                        slice_co_s;

  assign last_s = (idx_r == IDXW'(WORDS - 1));

  ripple_carry8 u_slice (
    .a  (a_r[idx_r]),
    .b  (b_r[idx_r]),
    .ci (carry_r),
    .s  (slice_s),
    .co (slice_co_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand latch and chunk-by-chunk accumulation; subtraction stores ~b and
  // seeds the carry with 1 to form the two's complement.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          sum_r[idx_r] <= slice_s;
          carry_r      <= slice_co_s;
          idx_r        <= idx_r + IDXW'(1);
          if (last_s) begin
            cout_r <= slice_co_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MWADD_OVF_EN
  logic ovf_r;

  // Signed overflow, judged on the post-inversion operand at the final chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if ((state_r == ST_RUN) && last_s) begin
      ovf_r <= (a_r[WORDS-1][W-1] == b_r[WORDS-1][W-1]) &&
               (slice_s[CHUNK_W-1] != a_r[WORDS-1][W-1]);
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.busy = (state_r == ST_RUN);
  assign bus.done = (state_r == ST_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Multi-cycle sequencer that performs wide add/subtract (W*WORDS bits) by time-multiplexing a single 8-bit ripple-carry adder slice, one 8-bit chunk per clock, LSB chunk first. The carry between chunks is held in a register. Operands are latched on start. The result is held until the next operation. It sits between a wide-operand client (ALU/accumulator logic) and the shared 8-bit adder datapath.

Parameters:
- W, 8, chunk width. Fixed to the adder slice width; any other value is illegal.
- WORDS, 4, number of chunks. Operand width = W*WORDS. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  W*WORDS  operand A; sampled with start
- b  input  W*WORDS  operand B; sampled with start
- busy  output  1  high while chunks are being computed
- done  output  1  one-cycle pulse; result valid
- sum  output  W*WORDS  result; held until the next accepted start
- cout  output  1  final carry out (sub: 1 = no borrow)

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge; dominates start):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand registers, chunk index and carry register all cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at edge k: latch a into A_r; latch (sub ? ~b : b) into B_r; carry_r <= sub; idx <= 0; go to RUN.
  - sum is not cleared on start; it is overwritten chunk by chunk.
- RUN:
  - Each cycle the slice computes {co, s} = A_r[idx] + B_r[idx] + carry_r.
  - At the edge: sum[idx*W +: W] <= s; carry_r <= co; idx <= idx+1.
  - When idx == WORDS-1: cout <= co and go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- busy = (state == RUN); done = (state == DONE). Both are decoded from registered state, so no combinational path from inputs.
- Latency: start sampled at edge k → chunk i written at edge k+1+i → done high in the cycle after edge k+WORDS. That is WORDS+1 edges from start to done; throughput is one operation per WORDS+2 cycles.
- start while RUN or DONE is ignored (no queuing). The caller must wait for IDLE. start may be asserted in the cycle done is high, but it is not accepted until the following cycle (IDLE).
- a, b and sub may change freely after the start edge; the latched copies are used.
- Arithmetic is modulo 2^(W*WORDS). Subtraction is two's complement: ~b + 1, with the +1 supplied via carry_r = 1 at chunk 0.
- Wrap-around example: all-ones + 1 gives sum 0, cout 1.

Optional Feature:
- Macro: MWADD_OVF_EN.
- With the macro defined:
  - Extra output ovf (1 bit), registered, reset 0.
  - Updated together with cout at the final chunk edge.
  - ovf = (A_r msb == B_r msb) && (s msb != A_r msb), using the post-inversion B_r, i.e. signed overflow.
  - Held until the next completed operation.
- Without the macro: no ovf port and no associated logic.

Decomposition:
- Shared package/include file holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - CHUNK_W=8
  - the width helper for idx: clog2(WORDS), minimum 1
- Exactly one sub-module instance: the team's 8-bit ripple-carry adder, ripple_carry8, used as the sole arithmetic slice. There is no other arithmetic in this block besides the operand inverter and the idx increment.

Test Plan (WORDS=4):
1. Reset then idle: rst=1 for 2 cycles → busy=0, done=0, sum=0, cout=0. With no start, outputs stay unchanged for 10 cycles.
2. Carry chaining: start, sub=0, a=0x000000FF, b=0x00000001 → busy for 4 cycles; done pulse in the cycle after the 4th edge; sum=0x00000100, cout=0.
3. Full wrap and subtraction:
   - a=0xFFFFFFFF + b=0x00000001 → sum=0x00000000, cout=1.
   - Then sub=1, a=5, b=7 → sum=0xFFFFFFFE, cout=0.
   - Then sub=1, a=7, b=5 → sum=0x00000002, cout=1.
4. Busy-start rejection: start 0x10+0x20; pulse start again in RUN cycle 2 with a=0xAAAAAAAA → only one done pulse; sum=0x00000030; state returns to IDLE.
5. Reset mid-operation: start 0x01020304+0x01010101; assert rst during RUN cycle 2 → next cycle busy=0, sum=0, and no done pulse. A fresh start afterwards yields the correct result 0x02030405.
6. With MWADD_OVF_EN defined:
   - 0x7FFFFFFF+0x00000001 → ovf=1, sum=0x80000000.
   - sub=1, 0x80000000-0x00000001 → ovf=1.
   - 0x00000001+0x00000001 → ovf=0.
